sphere3hopf_batch_ctrl: RTL and testbench
=========================================

# sphere3hopf_batch_ctrl

Batch sequencer in front of the 32-bit Sphere3Hopf FSM core. Accepts a command (start index, point count, base selects), issues one core computation per index with the correct start/ready/done handshake, and streams the resulting 4-D points out through a 2-entry valid/ready FIFO. The consumer can throttle the stream; an abort flushes the batch cleanly.

## Interface
- `WIDTH`, default 32: width of each result coordinate, Q16.16 signed.
- `CNT_W`, default 16: width of the point-count field.

Ports, listed as name, direction, width, meaning:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: high exactly when FSM is in IDLE (combinational).
- `cmd_k_start`, in, 32: first index of the batch.
- `cmd_count`, in, CNT_W: number of points in the batch.
- `cmd_base0` / `cmd_base1` / `cmd_base2`, in, 2 each: base-select codes; 2'b11 is illegal.
- `abort`, in, 1: synchronous abort request.
- `core_start`, out, 1: one-cycle start pulse to the core.
- `core_k`, out, 32: index presented to the core.
- `core_base_sel0..2`, out, 2 each: base selects presented to the core.
- `core_x` / `core_y` / `core_z` / `core_w`, in, WIDTH each: core results.
- `core_done`, in, 1: core result valid.
- `core_ready`, in, 1: core idle.
- `out_valid`, in/out: out, 1: FIFO head valid.
- `out_ready`, in, 1: consumer accepts the head.
- `out_x` / `out_y` / `out_z` / `out_w`, out, WIDTH each: point at the FIFO head.
- `out_k`, out, 32: index of the head point.
- `out_last`, out, 1: head is the final point of the batch.
- `busy`, out, 1: FSM not in IDLE, or FIFO not empty.
- `batch_done`, out, 1: one-cycle pulse at batch completion.
- `err`, out, 1: one-cycle pulse when a command is rejected.

## Operation
- **States:** IDLE, ISSUE, WAIT, DRAIN, ABORT_WAIT.
- **Command acceptance (IDLE):** a command is accepted when `cmd_valid & cmd_ready`. On acceptance, latch `k` = `cmd_k_start`, `rem` = `cmd_count`, and all three base selects.
  - Any base code 2'b11: pulse `err`, stay in IDLE, latch nothing.
  - `cmd_count` = 0: go to DRAIN. No core activity.
  - Otherwise: go to ISSUE.
- **ISSUE:** when `core_ready` = 1 and FIFO occupancy ≤ 1, assert `core_start` for one cycle, then go to WAIT. Otherwise hold.
  - `core_k` and `core_base_sel*` are driven from the latched registers. They are stable from the `core_start` cycle through the `core_done` capture.
- **WAIT:** on the first cycle `core_done` = 1, push {x, y, z, w, k, last = (`rem` == 1)} into the FIFO. Then set `k` ← `k` + 1 (mod 2^32) and `rem` ← `rem` − 1.
  - If the new `rem` = 0, go to DRAIN; else go to ISSUE.
- **DRAIN:** wait until the FIFO is empty, then pulse `batch_done` and go to IDLE.
- **FIFO:** 2 entries. The issue gate (occupancy ≤ 1) guarantees a free slot at capture, so overflow is impossible. A push and a pop in the same cycle are both honoured.
  - `out_*` show the head entry. They hold stable while `out_valid & !out_ready`.
- **Abort:** sampled in every state except IDLE.
  - From ISSUE or DRAIN: flush the FIFO, go to IDLE.
  - From WAIT (core in flight): go to ABORT_WAIT. Discard the result on `core_done`, flush the FIFO, go to IDLE.
  - No `batch_done` pulse on abort.
  - If abort coincides with the `core_done` capture in WAIT, abort wins and the result is discarded.
- **Result data:** passed through unmodified. No arithmetic beyond the `k` increment and `rem` decrement.

## Timing
- **Reset values:** `cmd_ready` = 1 (FSM in IDLE). All other outputs 0. FIFO empty. `k` = 0, `rem` = 0.
- **Reset mid-batch:** all state clears immediately (asynchronous). The core is not signalled; it is reset by the same `rst_n`.
- **Command to start:** accept at cycle 0 → `core_start` at cycle 1 at earliest (given `core_ready` = 1).
- **Done to output:** `core_done` sampled at cycle n → FIFO write at edge n → `out_valid` = 1 in cycle n+1.
- **Back-to-back:** next `core_start` no earlier than the cycle after capture.
- **Batch end:** `batch_done` is asserted the cycle after the pop of the last entry. `cmd_ready` = 1 in that same cycle.
- **Empty batch:** `batch_done` pulses the cycle after acceptance.
- **Error:** `err` pulses in the cycle after the rejected handshake.

## Test plan
- **Basic batch:** `cmd_k_start` = 1, `cmd_count` = 3, bases 00/01/10, `out_ready` = 1 → three `core_start` pulses with `core_k` = 1, 2, 3. `out_k` = 1, 2, 3, with `out_last` only on k = 3. Each point matches a standalone core run for the same k. One `batch_done` pulse.
- **Backpressure:** `out_ready` = 0, `cmd_count` = 4 → exactly 2 `core_start` pulses, then ISSUE holds with occupancy 2 and `out_*` stable. Raise `out_ready` → remaining 2 points delivered in order; total 4 outputs.
- **Index wrap:** `cmd_k_start` = 32'hFFFF_FFFF, `cmd_count` = 2 → `out_k` = FFFF_FFFF, then 0000_0000.
- **Empty and illegal commands:** `cmd_count` = 0 → no `core_start`, `batch_done` one cycle after accept. `cmd_base1` = 2'b11 → `err` pulse, no `core_start`, `cmd_ready` stays 1.
- **Abort in flight:** abort during WAIT of the 2nd point of a 5-point batch → no output for the in-flight point, FIFO flushed, no `batch_done`. A subsequent command with `cmd_count` = 1 runs normally.
- **Reset mid-operation:** `rst_n` = 0 while `out_valid` = 1 and the core is busy → all outputs at reset values within the same cycle. After release, `cmd_ready` = 1.

Source files
------------

// File: rtl/sphere3hopf_batch_ctrl.sv
// rtl/sphere3hopf_batch_ctrl.sv - batch sequencer feeding the Sphere3Hopf core with a 2-entry result FIFO
module sphere3hopf_batch_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_k_start,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [1:0]       cmd_base0,
    input  logic [1:0]       cmd_base1,
    input  logic [1:0]       cmd_base2,
    input  logic             abort,
    output logic             core_start,
    output logic [31:0]      core_k,
    output logic [1:0]       core_base_sel0,
    output logic [1:0]       core_base_sel1,
    output logic [1:0]       core_base_sel2,
    input  logic [WIDTH-1:0] core_x,
    input  logic [WIDTH-1:0] core_y,
    input  logic [WIDTH-1:0] core_z,
    input  logic [WIDTH-1:0] core_w,
    input  logic             core_done,
    input  logic             core_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic [WIDTH-1:0] out_w,
    output logic [31:0]      out_k,
    output logic             out_last,
    output logic             busy,
    output logic             batch_done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_ABORT_WAIT
    } state_t;

    localparam int EW = 4 * WIDTH + 33;

    state_t           state_q;
    logic [31:0]      k_q;
    logic [CNT_W-1:0] rem_q;
    logic [1:0]       b0_q, b1_q, b2_q;
    logic             batch_done_q, err_q;

    logic [EW-1:0]    mem_q [2];
    logic             rd_q, wr_q;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop, flush, illegal;
    logic [EW-1:0]    entry, head;

    assign illegal = (cmd_base0 == 2'b11) || (cmd_base1 == 2'b11) || (cmd_base2 == 2'b11);

    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE) || (cnt_q != 2'd0);
    assign core_k         = k_q;
    assign core_base_sel0 = b0_q;
    assign core_base_sel1 = b1_q;
    assign core_base_sel2 = b2_q;
    assign batch_done     = batch_done_q;
    assign err            = err_q;

    // Occupancy <= 1 at issue time guarantees a free slot when the result lands.
    assign core_start = (state_q == S_ISSUE) && core_ready && (cnt_q <= 2'd1) && !abort;
    assign push       = (state_q == S_WAIT) && core_done && !abort;
    assign out_valid  = (cnt_q != 2'd0);
    assign pop        = out_valid && out_ready;
    assign flush      = (abort && ((state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DRAIN)))
                      || (state_q == S_ABORT_WAIT);

    assign entry = {core_x, core_y, core_z, core_w, k_q, (rem_q == CNT_W'(1))};
    assign head  = mem_q[rd_q];
    assign {out_x, out_y, out_z, out_w, out_k, out_last} = head;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            if (flush) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wr_q] <= entry;
                    wr_q        <= ~wr_q;
                end
                if (pop) begin
                    rd_q <= ~rd_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            rem_q        <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            b2_q         <= '0;
            batch_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            batch_done_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            k_q   <= cmd_k_start;
                            rem_q <= cmd_count;
                            b0_q  <= cmd_base0;
                            b1_q  <= cmd_base1;
                            b2_q  <= cmd_base2;
                            // FIFO is always empty in IDLE, so an empty batch drains at once.
                            if (cmd_count == '0) begin
                                batch_done_q <= 1'b1;
                            end else begin
                                state_q <= S_ISSUE;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (core_start) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state_q <= core_done ? S_IDLE : S_ABORT_WAIT;
                    end else if (core_done) begin
                        k_q     <= k_q + 32'd1;
                        rem_q   <= rem_q - CNT_W'(1);
                        state_q <= (rem_q == CNT_W'(1)) ? S_DRAIN : S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (cnt_d == 2'd0) begin
                        batch_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                S_ABORT_WAIT: begin
                    if (core_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sphere3hopf_batch_ctrl.sv
// tb/tb_sphere3hopf_batch_ctrl.sv - directed scoreboard bench for sphere3hopf_batch_ctrl
module tb_sphere3hopf_batch_ctrl;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_k_start;
    logic [15:0] cmd_count;
    logic [1:0]  cmd_base0, cmd_base1, cmd_base2;
    logic        abort;
    logic        core_start;
    logic [31:0] core_k;
    logic [1:0]  core_base_sel0, core_base_sel1, core_base_sel2;
    logic [31:0] core_x, core_y, core_z, core_w;
    logic        core_done, core_ready;
    logic        out_valid, out_ready;
    logic [31:0] out_x, out_y, out_z, out_w, out_k;
    logic        out_last, busy, batch_done, err;

    sphere3hopf_batch_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k_start(cmd_k_start),
        .cmd_count(cmd_count), .cmd_base0(cmd_base0), .cmd_base1(cmd_base1), .cmd_base2(cmd_base2),
        .abort(abort), .core_start(core_start), .core_k(core_k),
        .core_base_sel0(core_base_sel0), .core_base_sel1(core_base_sel1), .core_base_sel2(core_base_sel2),
        .core_x(core_x), .core_y(core_y), .core_z(core_z), .core_w(core_w),
        .core_done(core_done), .core_ready(core_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_w(out_w),
        .out_k(out_k), .out_last(out_last), .busy(busy), .batch_done(batch_done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int bds    = 0;
    int recv   = 0;
    int core_lat = 2;

    typedef struct {
        logic [31:0] k;
        logic        last;
        logic [31:0] x, y, z, w;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] fx(input logic [31:0] k, input logic [1:0] b);
        return k * 32'h0001_0001 + {30'd0, b};
    endfunction
    function automatic logic [31:0] fy(input logic [31:0] k, input logic [1:0] b);
        return ~k + {30'd0, b};
    endfunction
    function automatic logic [31:0] fz(input logic [31:0] k, input logic [1:0] b);
        return {k[15:0], k[31:16]} ^ {30'd0, b};
    endfunction
    function automatic logic [31:0] fw(input logic [31:0] k);
        return k + 32'h0001_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural core: latches k/bases on start, answers core_lat cycles later.
    logic        cbusy;
    int          ccnt;
    logic [31:0] ck_q;
    logic [1:0]  cb0_q, cb1_q, cb2_q;
    assign core_ready = rst_n && !cbusy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cbusy <= 1'b0; ccnt <= 0; core_done <= 1'b0; ck_q <= '0;
            cb0_q <= '0; cb1_q <= '0; cb2_q <= '0;
            core_x <= '0; core_y <= '0; core_z <= '0; core_w <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_start && !cbusy) begin
                cbusy <= 1'b1; ccnt <= core_lat; ck_q <= core_k;
                cb0_q <= core_base_sel0; cb1_q <= core_base_sel1; cb2_q <= core_base_sel2;
            end else if (cbusy) begin
                if (ccnt == 0) begin
                    cbusy     <= 1'b0;
                    core_done <= 1'b1;
                    core_x    <= fx(ck_q, cb0_q);
                    core_y    <= fy(ck_q, cb1_q);
                    core_z    <= fz(ck_q, cb2_q);
                    core_w    <= fw(ck_q);
                end else begin
                    ccnt <= ccnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start) starts++;
            if (batch_done) bds++;
            if (core_done) check("core_k_hold", core_k, ck_q);
            if (out_valid && out_ready) begin
                exp_t e;
                recv++;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_out: got out_k %0h with nothing expected", out_k);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_k", out_k, e.k);
                    check("out_last", out_last, e.last);
                    check("out_x", out_x, e.x);
                    check("out_y", out_y, e.y);
                    check("out_z", out_z, e.z);
                    check("out_w", out_w, e.w);
                end
            end
        end
    end

    task automatic push_one(input logic [31:0] k, input logic last,
                            input logic [1:0] b0, input logic [1:0] b1, input logic [1:0] b2);
        exp_t e;
        e.k = k; e.last = last;
        e.x = fx(k, b0); e.y = fy(k, b1); e.z = fz(k, b2); e.w = fw(k);
        sb.push_back(e);
    endtask

    task automatic push_exp(input logic [31:0] k, input int cnt,
                            input logic [1:0] b0, input logic [1:0] b1, input logic [1:0] b2);
        logic [31:0] kk;
        kk = k;
        for (int i = 0; i < cnt; i++) begin
            push_one(kk, (i == cnt - 1), b0, b1, b2);
            kk = kk + 32'd1;
        end
    endtask

    task automatic send_cmd(input logic [31:0] k, input logic [15:0] cnt,
                            input logic [1:0] b0, input logic [1:0] b1, input logic [1:0] b2);
        int t = 0;
        while (!cmd_ready && t < 300) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        assert (cmd_ready) else begin
            errors++;
            $error("FAIL cmd_ready_timeout: got %0d expected 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_k_start = k; cmd_count = cnt;
        cmd_base0 = b0; cmd_base1 = b1; cmd_base2 = b2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_bd(input int target);
        int t = 0;
        while (bds < target && t < 300) begin
            @(posedge clk); t++;
        end
        #1;
        checks++;
        assert (bds >= target) else begin
            errors++;
            $error("FAIL batch_done_timeout: got %0d expected %0d", bds, target);
        end
    endtask

    int s0, b0, r0, t;
    logic [31:0] hx;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_k_start = '0; cmd_count = '0;
        cmd_base0 = '0; cmd_base1 = '0; cmd_base2 = '0; abort = 1'b0; out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_core_start", core_start, 0);
        check("rst_batch_done", batch_done, 0);
        check("rst_err", err, 0);
        check("rst_core_k", core_k, 0);
        check("rst_out_k", out_k, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic batch
        s0 = starts; b0 = bds; r0 = recv; core_lat = 3;
        push_exp(32'd1, 3, 2'b00, 2'b01, 2'b10);
        send_cmd(32'd1, 16'd3, 2'b00, 2'b01, 2'b10);
        check("basic_start_cycle1", core_start, 1);
        check("basic_core_k", core_k, 1);
        wait_bd(b0 + 1);
        repeat (2) @(posedge clk); #1;
        check("basic_starts", starts - s0, 3);
        check("basic_bd", bds - b0, 1);
        check("basic_recv", recv - r0, 3);
        check("basic_sb_empty", sb.size(), 0);

        // Backpressure
        s0 = starts; b0 = bds; r0 = recv; out_ready = 1'b0; core_lat = 1;
        push_exp(32'd100, 4, 2'b01, 2'b00, 2'b10);
        send_cmd(32'd100, 16'd4, 2'b01, 2'b00, 2'b10);
        repeat (30) @(posedge clk); #1;
        check("bp_starts_held", starts - s0, 2);
        check("bp_out_valid", out_valid, 1);
        check("bp_head_k", out_k, 100);
        check("bp_busy", busy, 1);
        hx = out_x;
        repeat (5) @(posedge clk); #1;
        check("bp_head_stable_x", out_x, hx);
        check("bp_head_stable_k", out_k, 100);
        check("bp_starts_still", starts - s0, 2);
        out_ready = 1'b1;
        wait_bd(b0 + 1);
        check("bp_recv", recv - r0, 4);
        check("bp_starts_total", starts - s0, 4);

        // Index wrap
        r0 = recv; b0 = bds;
        push_exp(32'hFFFF_FFFF, 2, 2'b10, 2'b10, 2'b10);
        send_cmd(32'hFFFF_FFFF, 16'd2, 2'b10, 2'b10, 2'b10);
        wait_bd(b0 + 1);
        check("wrap_recv", recv - r0, 2);

        // Empty batch
        @(posedge clk); #1;
        s0 = starts; b0 = bds;
        send_cmd(32'd5, 16'd0, 2'b00, 2'b00, 2'b00);
        check("empty_bd_pulse", batch_done, 1);
        check("empty_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        check("empty_bd_drop", batch_done, 0);
        check("empty_no_start", starts - s0, 0);

        // Illegal base
        s0 = starts; b0 = bds;
        send_cmd(32'd7, 16'd2, 2'b00, 2'b11, 2'b01);
        check("illegal_err", err, 1);
        check("illegal_cmd_ready", cmd_ready, 1);
        check("illegal_busy", busy, 0);
        @(posedge clk); #1;
        check("illegal_err_drop", err, 0);
        check("illegal_no_start", starts - s0, 0);
        check("illegal_no_bd", bds - b0, 0);

        // Abort in flight on the 2nd point
        s0 = starts; b0 = bds; r0 = recv; core_lat = 4;
        push_one(32'd200, 1'b0, 2'b01, 2'b01, 2'b01);
        send_cmd(32'd200, 16'd5, 2'b01, 2'b01, 2'b01);
        t = 0;
        while ((starts - s0) < 2 && t < 200) begin
            @(posedge clk); t++;
        end
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_out_valid", out_valid, 0);
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        repeat (3) @(posedge clk); #1;
        check("abort_idle", cmd_ready, 1);
        check("abort_no_bd", bds - b0, 0);
        check("abort_recv", recv - r0, 1);
        check("abort_starts", starts - s0, 2);
        check("abort_sb_empty", sb.size(), 0);
        check("abort_flushed", out_valid, 0);
        b0 = bds; r0 = recv;
        push_exp(32'd300, 1, 2'b00, 2'b10, 2'b01);
        send_cmd(32'd300, 16'd1, 2'b00, 2'b10, 2'b01);
        wait_bd(b0 + 1);
        check("post_abort_recv", recv - r0, 1);

        // Reset mid-operation
        out_ready = 1'b0; core_lat = 3;
        push_exp(32'd400, 3, 2'b10, 2'b01, 2'b00);
        send_cmd(32'd400, 16'd3, 2'b10, 2'b01, 2'b00);
        t = 0;
        while (!(out_valid && cbusy) && t < 200) begin
            @(negedge clk); t++;
        end
        check("midrst_setup", out_valid && cbusy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_core_start", core_start, 0);
        check("midrst_out_k", out_k, 0);
        check("midrst_core_k", core_k, 0);
        sb.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
